// File: rtl/hamming_pkg.sv
// Shared constants, state type and expected-syndrome rule for the Hamming(7,4) injection self-test.
// HAMMING_CLEAN_PASS_EN adds a no-error vector at index 7 of every data word.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;
    localparam int POS_W  = 3;

`ifdef HAMMING_CLEAN_PASS_EN
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(CODE_W);
`else
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(CODE_W - 1);
`endif
    localparam logic [DATA_W-1:0] LAST_DATA = DATA_W'(15);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    // Codeword bit i is Hamming position i+1; the clean vector decodes with a zero syndrome.
    function automatic logic [POS_W-1:0] exp_syndrome(input logic [POS_W-1:0] pos);
`ifdef HAMMING_CLEAN_PASS_EN
        if (pos == POS_W'(CODE_W)) return '0;
`endif
        return pos + POS_W'(1);
    endfunction

endpackage

// File: rtl/hamming_vec_seq.sv
// Nested data/position vector counter: position is the inner loop, data word the outer loop.
// Flags the final vector of the sweep so the controller can stop without advancing past it.
module hamming_vec_seq
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] data_word,
    output logic [POS_W-1:0]  error_pos,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            data_word <= '0;
            error_pos <= '0;
        end else if (advance) begin
            if (error_pos == LAST_POS) begin
                error_pos <= '0;
                data_word <= data_word + DATA_W'(1);
            end else begin
                error_pos <= error_pos + POS_W'(1);
            end
        end
    end

    assign last = (data_word == LAST_DATA) && (error_pos == LAST_POS);

endmodule

// File: rtl/hamming_inject_ctrl.sv
// Self-test sequencer for the encoder -> error_inject -> decoder chain: sweeps, scores, captures first failure.
// HAMMING_CLEAN_PASS_EN adds the clean vector per data word and the inj_en output.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for start; results of the last campaign held
// ST_SETTLE | vector driven, settle timer counting down
// ST_CHECK  | one cycle: score decoder outputs, advance or finish
module hamming_inject_ctrl
    import hamming_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [DATA_W-1:0] data_word,
    output logic [POS_W-1:0]  error_pos,
`ifdef HAMMING_CLEAN_PASS_EN
    output logic              inj_en,
`endif
    input  logic [DATA_W-1:0] dec_data,
    input  logic [POS_W-1:0]  dec_syndrome,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              first_fail_valid,
    output logic [DATA_W-1:0] first_fail_data,
    output logic [POS_W-1:0]  first_fail_pos
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt;
    logic       seq_load, seq_adv, seq_last;
    logic       vec_pass;

    hamming_vec_seq u_vec_seq (
        .clk       (clk),
        .rst       (rst),
        .load      (seq_load),
        .advance   (seq_adv),
        .data_word (data_word),
        .error_pos (error_pos),
        .last      (seq_last)
    );

    assign vec_pass = (dec_data == data_word) && (dec_syndrome == exp_syndrome(error_pos));
    assign busy     = (state != ST_IDLE);
`ifdef HAMMING_CLEAN_PASS_EN
    assign inj_en   = (error_pos != LAST_POS);
`endif

    always_comb begin
        state_nxt = state;
        seq_load  = 1'b0;
        seq_adv   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_SETTLE;
                    seq_load  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort)                  state_nxt = ST_IDLE;
                else if (settle_cnt == 4'd1) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort || seq_last) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_SETTLE;
                    seq_adv   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            settle_cnt       <= '0;
            done             <= 1'b0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_data  <= '0;
            first_fail_pos   <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (seq_load) begin
                        settle_cnt       <= SETTLE_LOAD;
                        pass_cnt         <= '0;
                        fail_cnt         <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_data  <= '0;
                        first_fail_pos   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!abort) settle_cnt <= settle_cnt - 4'd1;
                end
                ST_CHECK: begin
                    // An aborted CHECK leaves the partial score untouched.
                    if (!abort) begin
                        if (vec_pass) begin
                            if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                        end else begin
                            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_data  <= data_word;
                                first_fail_pos   <= error_pos;
                            end
                        end
                        if (seq_last) done <= 1'b1;
                        else          settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_inject_ctrl.sv
// Bench for hamming_inject_ctrl: a behavioural Hamming(7,4) chain drives the decoder inputs,
// and a vector-list model predicts counts, first failure and done timing.
`timescale 1ns/1ps
module tb_hamming_inject_ctrl;

`ifdef HAMMING_CLEAN_PASS_EN
    localparam int NPOS = 8;
`else
    localparam int NPOS = 7;
`endif
    localparam int NVEC = 16 * NPOS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // instance A: SETTLE_CYCLES=1, CNT_W=8
    logic       start_a = 1'b0, abort_a = 1'b0;
    logic [3:0] dw_a, dd_a, ffd_a;
    logic [2:0] ep_a, ds_a, ffp_a;
    logic       busy_a, done_a, ffv_a, inj_a_w;
    logic [7:0] pc_a, fc_a;
    int         mode_a = 0;

    // instance B: SETTLE_CYCLES=3, CNT_W=6 (saturates inside one campaign)
    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [3:0] dw_b, dd_b, ffd_b;
    logic [2:0] ep_b, ds_b, ffp_b;
    logic       busy_b, done_b, ffv_b, inj_b_w;
    logic [5:0] pc_b, fc_b;
    logic       garb_b = 1'b0;
    int         phase_b = 0;
    logic [3:0] g_mask = 4'h1;
    logic [2:0] g_smask = 3'h0;

    bit plan [128];

`ifdef HAMMING_CLEAN_PASS_EN
    logic inj_a, inj_b;
    assign inj_a_w = inj_a;
    assign inj_b_w = inj_b;
`else
    assign inj_a_w = 1'b1;
    assign inj_b_w = 1'b1;
`endif

    hamming_inject_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .data_word(dw_a), .error_pos(ep_a),
`ifdef HAMMING_CLEAN_PASS_EN
        .inj_en(inj_a),
`endif
        .dec_data(dd_a), .dec_syndrome(ds_a), .busy(busy_a), .done(done_a),
        .pass_cnt(pc_a), .fail_cnt(fc_a), .first_fail_valid(ffv_a),
        .first_fail_data(ffd_a), .first_fail_pos(ffp_a)
    );

    hamming_inject_ctrl #(.SETTLE_CYCLES(3), .CNT_W(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .data_word(dw_b), .error_pos(ep_b),
`ifdef HAMMING_CLEAN_PASS_EN
        .inj_en(inj_b),
`endif
        .dec_data(dd_b), .dec_syndrome(ds_b), .busy(busy_b), .done(done_b),
        .pass_cnt(pc_b), .fail_cnt(fc_b), .first_fail_valid(ffv_b),
        .first_fail_data(ffd_b), .first_fail_pos(ffp_b)
    );

    // Real encode / single-bit flip / syndrome-decode, then optional decoder faults by mode:
    // 0 ideal, 1 data forced to 0, 2 syndrome = pos+2, 3 planned corruption for this vector.
    function automatic logic [6:0] chain(input int md, input logic [3:0] d, input logic [2:0] p,
                                         input logic inj, input bit bad);
        logic [7:1] c;
        logic [2:0] s;
        logic [3:0] od;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        if (inj && p != 3'd7) c[int'(p) + 1] = ~c[int'(p) + 1];
        s = 3'd0;
        for (int i = 1; i <= 7; i++) if (c[i]) s = s ^ 3'(i);
        if (s != 3'd0) c[s] = ~c[s];
        od = {c[7], c[6], c[5], c[3]};
        case (md)
            1: od = 4'h0;
            2: s = p + 3'd2;
            3: if (bad) begin
                   if (p[0]) s = s ^ 3'b100;
                   else      od = od ^ 4'h9;
               end
            default: ;
        endcase
        return {od, s};
    endfunction

    function automatic logic [2:0] esyn(input logic [2:0] p);
        return (p == 3'd7) ? 3'd0 : p + 3'd1;
    endfunction

    function automatic logic [6:0] vec_code(input int v);
        return {4'(v / NPOS), 3'(v % NPOS)};
    endfunction

    always_comb begin
        {dd_a, ds_a} = chain(mode_a, dw_a, ep_a, inj_a_w, plan[int'(dw_a) * NPOS + int'(ep_a)]);
    end

    always_comb begin
        {dd_b, ds_b} = chain(0, dw_b, ep_b, inj_b_w, 1'b0);
        if (garb_b && (phase_b % 4 != 3)) begin
            dd_b = dd_b ^ g_mask;
            ds_b = ds_b ^ g_smask;
        end
    end

    always @(posedge clk) begin
        g_mask  <= 4'($urandom_range(1, 15));
        g_smask <= 3'($urandom_range(0, 7));
        phase_b <= start_b ? 0 : phase_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int md, input int nrun, input int cmax,
                         output int e_pass, output int e_fail, output logic e_ffv,
                         output logic [3:0] e_ffd, output logic [2:0] e_ffp);
        logic [6:0] o;
        logic [3:0] d;
        logic [2:0] p;
        e_pass = 0; e_fail = 0; e_ffv = 1'b0; e_ffd = 4'h0; e_ffp = 3'h0;
        for (int v = 0; v < nrun; v++) begin
            d = 4'(v / NPOS);
            p = 3'(v % NPOS);
            o = chain(md, d, p, p != 3'd7, plan[v]);
            if (o[6:3] == d && o[2:0] == esyn(p)) begin
                if (e_pass < cmax) e_pass++;
            end else begin
                if (e_fail < cmax) e_fail++;
                if (!e_ffv) begin e_ffv = 1'b1; e_ffd = d; e_ffp = p; end
            end
        end
    endtask

    task automatic verify_a(input int md, input int nrun);
        int e_pass, e_fail;
        logic e_ffv;
        logic [3:0] e_ffd;
        logic [2:0] e_ffp;
        model(md, nrun, 255, e_pass, e_fail, e_ffv, e_ffd, e_ffp);
        check("pass_cnt_a", pc_a, e_pass);
        check("fail_cnt_a", fc_a, e_fail);
        check("ff_valid_a", ffv_a, e_ffv);
        check("ff_data_a", ffd_a, e_ffd);
        check("ff_pos_a", ffp_a, e_ffp);
    endtask

    // Runs one campaign on A; start is re-pulsed mid-run and must be ignored.
    task automatic run_a(input int md, input int abort_at, output int done_cyc);
        int v;
        mode_a  = md;
        start_a = 1'b1;
        tick();
        start_a  = 1'b0;
        done_cyc = -1;
        for (int n = 0; n < 2 * NVEC + 4; n++) begin
            v = n / 2;
            check("busy_a", busy_a, 1);
            check("vec_a", {dw_a, ep_a}, vec_code(v));
`ifdef HAMMING_CLEAN_PASS_EN
            check("inj_en_a", inj_a_w, (v % NPOS) != 7);
`endif
            if (n == 7)        start_a = 1'b1;
            if (n == abort_at) abort_a = 1'b1;
            tick();
            start_a = 1'b0;
            abort_a = 1'b0;
            if (n == abort_at) begin
                check("abort_idle_a", busy_a, 0);
                check("abort_nodone_a", done_a, 0);
                break;
            end
            if (done_a) begin
                done_cyc = n + 1;
                break;
            end
        end
    endtask

    task automatic finish_a(input int md, input int dc);
        check("done_time_a", dc, NVEC * 2);
        check("last_vec_a", {dw_a, ep_a}, vec_code(NVEC - 1));
        verify_a(md, NVEC);
        tick();
        check("done_pulse_a", done_a, 0);
        check("idle_after_a", busy_a, 0);
    endtask

    initial begin
        int dc, ab, v;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, ab, v;
        for (int i = 0; i < 128; i++) plan[i] = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_vec_a", {dw_a, ep_a}, 0);
        check("rst_cnt_a", {pc_a, fc_a}, 0);
        check("rst_ff_a", {ffv_a, ffd_a, ffp_a}, 0);
        check("rst_b", {busy_b, done_b, pc_b, fc_b, ffv_b, dw_b, ep_b}, 0);
        rst = 1'b0;
        tick();

        for (int md = 0; md < 3; md++) begin
            run_a(md, -1, dc);
            finish_a(md, dc);
        end

        for (int i = 0; i < NVEC; i++) plan[i] = ($urandom_range(0, 3) == 0);
        run_a(3, -1, dc);
        finish_a(3, dc);

        run_a(0, 50, dc);
        verify_a(0, 25);
        check("abort_pass25_a", pc_a, 25);
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("start_abort_idle_a", busy_a, 0);
        tick();
        check("start_abort_idle2_a", busy_a, 0);
        verify_a(0, 25);

        for (int i = 0; i < NVEC; i++) plan[i] = ($urandom_range(0, 2) == 0);
        ab = $urandom_range(2, 2 * NVEC - 3);
        run_a(3, ab, dc);
        verify_a(3, ab / 2);

        mode_a  = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy_a", busy_a, 0);
        check("midrst_vec_a", {dw_a, ep_a}, 0);
        check("midrst_cnt_a", {pc_a, fc_a, ffv_a}, 0);
        tick();

        garb_b  = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        dc = -1;
        for (int n = 0; n < 4 * NVEC + 4; n++) begin
            v = n / 4;
            check("vec_b", {dw_b, ep_b}, vec_code(v));
            tick();
            if (done_b) begin
                dc = n + 1;
                break;
            end
        end
        check("done_time_b", dc, NVEC * 4);
        check("pass_sat_b", pc_b, 63);
        check("fail_cnt_b", fc_b, 0);
        check("ff_valid_b", {ffv_b, ffd_b, ffp_b}, 0);
        tick();
        check("done_pulse_b", done_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
